rr_dff_write_arbiter: RTL

- Round-robin arbiter that shares one WIDTH-bit D flip-flop storage register between N_REQ requesters.
- Each granted requester writes its data word into the shared register and receives a one-cycle ack.
- Sits between independent producer blocks and the common state register, and sequences every load of that register.

---
 rtl/rr_dff_write_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/rr_dff_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_dff_write_arbiter
// Description : Round-robin arbiter sequencing writes from N_REQ producers into
//               one shared WIDTH-bit register, with per-requester grant/ack.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_dff_write_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    localparam int IDW  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] data,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid,
    output logic [IDW-1:0]         q_src,
    output logic                   busy
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_load = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]       r_state, w_nxt_state;
    logic [N_REQ-1:0] r_gnt, w_nxt_gnt;
    logic [N_REQ-1:0] r_ack, w_nxt_ack;
    logic [WIDTH-1:0] r_q, w_nxt_q;
    logic             r_qv, w_nxt_qv;
    logic [IDW-1:0]   r_src, w_nxt_src;
    logic [IDW-1:0]   r_ptr, w_nxt_ptr;
    logic [IDW-1:0]   r_win, w_nxt_win;
    logic             r_busy;

    logic             w_found;
    logic [IDW-1:0]   w_win;
    logic [N_REQ-1:0] w_onehot;
    logic [WIDTH-1:0] w_wdata;
    int               w_idx;

    // Rotating priority search starting at the pointer.
    always_comb begin
        w_found  = 1'b0;
        w_win    = '0;
        w_idx    = 0;
        w_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
            if (!w_found && req[w_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[IDW-1:0];
            end
        end
        w_onehot[w_win] = 1'b1;
    end

    assign w_wdata = data[int'(r_win)*WIDTH +: WIDTH];

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_gnt   = r_gnt;
        w_nxt_ack   = r_ack;
        w_nxt_q     = r_q;
        w_nxt_qv    = r_qv;
        w_nxt_src   = r_src;
        w_nxt_ptr   = r_ptr;
        w_nxt_win   = r_win;
        case (r_state)
            c_idle: begin
                if (w_found) begin
                    w_nxt_gnt   = w_onehot;
                    w_nxt_win   = w_win;
                    w_nxt_state = c_load;
                end
            end
            c_load: begin
                // Commit regardless of req: a granted write always completes.
                w_nxt_q     = w_wdata;
                w_nxt_src   = r_win;
                w_nxt_qv    = 1'b1;
                w_nxt_ack   = r_gnt;
                w_nxt_ptr   = (r_win == IDW'(N_REQ-1)) ? '0 : r_win + 1'b1;
                w_nxt_state = c_done;
            end
            c_done: begin
                w_nxt_gnt   = '0;
                w_nxt_ack   = '0;
                w_nxt_state = c_idle;
            end
            default: begin
                w_nxt_gnt   = '0;
                w_nxt_ack   = '0;
                w_nxt_state = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_q     <= '0;
            r_qv    <= 1'b0;
            r_src   <= '0;
            r_ptr   <= '0;
            r_win   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_gnt   <= w_nxt_gnt;
            r_ack   <= w_nxt_ack;
            r_q     <= w_nxt_q;
            r_qv    <= w_nxt_qv;
            r_src   <= w_nxt_src;
            r_ptr   <= w_nxt_ptr;
            r_win   <= w_nxt_win;
            r_busy  <= (w_nxt_state != c_idle);
        end
    end

    assign gnt     = r_gnt;
    assign ack     = r_ack;
    assign q       = r_q;
    assign q_valid = r_qv;
    assign q_src   = r_src;
    assign busy    = r_busy;

endmodule
`default_nettype wire
